stream_fifo_v4: RTL and testbench

- Parametrised successor FIFO with a valid/ready stream interface on both sides.
- Supports any DEPTH ≥ 1, including non-power-of-2, with explicit pointer wrap.
- Optional fall-through bypass, runtime almost-full/almost-empty thresholds, and a high-watermark usage monitor.
- Used as the generic buffer in AXI crossbar channel slices (AW/W/B/AR/R queues) where the producer must see backpressure rather than silent drops.

---
 rtl/stream_fifo_v4_pkg.sv | 24 ++
 rtl/stream_fifo_v4_if.sv | 35 +++
 rtl/stream_fifo_v4_ctrl.sv | 90 +++++++++
 rtl/stream_fifo_v4.sv | 84 ++++++++
 tb/tb_stream_fifo_v4.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_fifo_v4_pkg.sv
// Shared FIFO helpers: counter sizing, wrap-to-zero pointer increment, operation encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stream_fifo_pkg;

    // Per-cycle queue operation after bypass has been removed.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Bits needed to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Increment with explicit wrap at depth-1, valid for any depth (no modulo).
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/stream_fifo_v4_if.sv
// Stream FIFO bus: upstream/downstream valid-ready handshakes, flush, thresholds, status.
// Latency: n/a (wiring only).
// Backpressure: ready_o is the FIFO's grant to the producer; ready_i is the consumer's grant.
interface stream_fifo_v4_if #(
    parameter int unsigned DEPTH = 8,
    parameter type         dtype = logic [31:0]
);
    localparam int unsigned CNT_WIDTH = stream_fifo_pkg::cnt_width(DEPTH);

    logic                 flush_i;
    logic                 valid_i;
    logic                 ready_o;
    dtype                 data_i;
    logic                 valid_o;
    logic                 ready_i;
    dtype                 data_o;
    logic [CNT_WIDTH-1:0] af_thresh_i;
    logic [CNT_WIDTH-1:0] ae_thresh_i;
    logic [CNT_WIDTH-1:0] usage_o;
    logic                 almost_full_o;
    logic                 almost_empty_o;
    logic [CNT_WIDTH-1:0] max_usage_o;

    // FIFO side.
    modport slave (
        input  flush_i, valid_i, data_i, ready_i, af_thresh_i, ae_thresh_i,
        output ready_o, valid_o, data_o, usage_o, almost_full_o, almost_empty_o, max_usage_o
    );

    // Producer/consumer/controller side.
    modport master (
        output flush_i, valid_i, data_i, ready_i, af_thresh_i, ae_thresh_i,
        input  ready_o, valid_o, data_o, usage_o, almost_full_o, almost_empty_o, max_usage_o
    );
endinterface

// File: rtl/stream_fifo_v4_ctrl.sv
// FIFO control: pointers, fill count, threshold flags and high watermark (no payload).
// Latency: state updates on the clock edge; ready/valid/flags are combinational from state.
// Backpressure: ready_o = not full, independent of ready_i; flush drops the same-cycle push.
// Ports: handshake in (valid_i, ready_i, flush_i), thresholds in; ready/valid, write enable,
//        pointers, empty, usage/watermark and flags out.
module stream_fifo_v4_ctrl
    import stream_fifo_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned CNT_WIDTH    = cnt_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic                  ready_i,
    input  logic [CNT_WIDTH-1:0]  af_thresh_i,
    input  logic [CNT_WIDTH-1:0]  ae_thresh_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic                  empty_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] wr_ptr_o,
    output logic [ADDR_WIDTH-1:0] rd_ptr_o,
    output logic [CNT_WIDTH-1:0]  usage_o,
    output logic [CNT_WIDTH-1:0]  max_usage_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o
);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d, max_q, max_d;
    logic                  push, pop, bypass;
    fifo_op_e              op;

    assign empty_o = (count_q == '0);
    assign ready_o = (count_q != FULL_CNT);
    // In fall-through mode an empty FIFO presents the upstream beat directly.
    assign valid_o = !empty_o || (FALL_THROUGH && valid_i);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;
    // Beat goes straight through: nothing is stored and no state moves.
    assign bypass  = FALL_THROUGH && empty_o && push && pop;
    assign op      = fifo_op_e'({push && !bypass, pop && !bypass});
    assign we_o    = push && !bypass && !flush_i;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        case (op)
            OP_PUSH: count_d = count_q + CNT_WIDTH'(1);
            OP_POP:  count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
        if (op == OP_PUSH || op == OP_BOTH) wr_ptr_d = ADDR_WIDTH'(ptr_inc(32'(wr_ptr_q), DEPTH));
        if (op == OP_POP  || op == OP_BOTH) rd_ptr_d = ADDR_WIDTH'(ptr_inc(32'(rd_ptr_q), DEPTH));
        max_d = (count_d > max_q) ? count_d : max_q;
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            max_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            max_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            max_q    <= max_d;
        end
    end

    assign wr_ptr_o       = wr_ptr_q;
    assign rd_ptr_o       = rd_ptr_q;
    assign usage_o        = count_q;
    assign max_usage_o    = max_q;
    assign almost_full_o  = (count_q >= af_thresh_i);
    assign almost_empty_o = (count_q <= ae_thresh_i);
endmodule

// File: rtl/stream_fifo_v4.sv
// Stream FIFO, any DEPTH >= 1, optional fall-through, thresholds and watermark.
// Latency: 1 cycle write-to-valid (0 cycles with FALL_THROUGH on an empty FIFO).
// Backpressure: ready_o deasserts when full; producer must hold data while stalled.
// Ports: clk_i, rst_ni (async active-low), bus (slave modport of stream_fifo_v4_if).
module stream_fifo_v4
    import stream_fifo_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [31:0],
    parameter int unsigned ADDR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned CNT_WIDTH    = cnt_width(DEPTH)
) (
    input logic             clk_i,
    input logic             rst_ni,
    stream_fifo_v4_if.slave bus
);
    if (DEPTH == 0) begin : g_depth_chk
        $error("stream_fifo_v4: DEPTH must be >= 1");
    end

    logic                  we, empty;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    dtype                  mem_q [DEPTH];

    stream_fifo_v4_ctrl #(
        .FALL_THROUGH (FALL_THROUGH),
        .DEPTH        (DEPTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_ctrl (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (bus.flush_i),
        .valid_i        (bus.valid_i),
        .ready_i        (bus.ready_i),
        .af_thresh_i    (bus.af_thresh_i),
        .ae_thresh_i    (bus.ae_thresh_i),
        .ready_o        (bus.ready_o),
        .valid_o        (bus.valid_o),
        .empty_o        (empty),
        .we_o           (we),
        .wr_ptr_o       (wr_ptr),
        .rd_ptr_o       (rd_ptr),
        .usage_o        (bus.usage_o),
        .max_usage_o    (bus.max_usage_o),
        .almost_full_o  (bus.almost_full_o),
        .almost_empty_o (bus.almost_empty_o)
    );

    // Payload storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (we) mem_q[wr_ptr] <= bus.data_i;
    end

    // Masked to zero when idle so downstream checkers never see stale or X data.
    assign bus.data_o = !bus.valid_o               ? '0          :
                        (FALL_THROUGH && empty)    ? bus.data_i  :
                                                     mem_q[rd_ptr];

`ifndef SYNTHESIS
    logic hold_q;
    dtype data_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q <= 1'b0;
            data_q <= '0;
        end else begin
            hold_q <= bus.valid_i && !bus.ready_o && !bus.flush_i;
            data_q <= bus.data_i;
        end
    end
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (bus.usage_o <= CNT_WIDTH'(DEPTH))
                else $error("stream_fifo_v4: count exceeds DEPTH");
            assert (!(bus.valid_i && bus.ready_o && bus.usage_o == CNT_WIDTH'(DEPTH)))
                else $error("stream_fifo_v4: push while full");
            assert (!hold_q || bus.data_i == data_q)
                else $error("stream_fifo_v4: data_i changed while stalled");
        end
    end
`endif
endmodule

// File: tb/tb_stream_fifo_v4.sv
// Bench: three FIFOs (D5 non-FT, D8 non-FT, D6 fall-through) share one stimulus stream.
// Each is compared every cycle against a queue-based model plus directed spot checks.
// Producer holds data_i while any instance stalls it.
module tb_stream_fifo_v4;
    localparam int DEP [3] = '{5, 8, 6};
    localparam bit FTM [3] = '{1'b0, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0, ready_i = 1'b0, flush_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [3:0]  af_th = '0, ae_th = '0;

    always #5 clk = ~clk;

    stream_fifo_v4_if #(.DEPTH(5)) if0 ();
    stream_fifo_v4_if #(.DEPTH(8)) if1 ();
    stream_fifo_v4_if #(.DEPTH(6)) if2 ();

    stream_fifo_v4 #(.FALL_THROUGH(1'b0), .DEPTH(5)) u_d5 (.clk_i(clk), .rst_ni(rst_n), .bus(if0.slave));
    stream_fifo_v4 #(.FALL_THROUGH(1'b0), .DEPTH(8)) u_d8 (.clk_i(clk), .rst_ni(rst_n), .bus(if1.slave));
    stream_fifo_v4 #(.FALL_THROUGH(1'b1), .DEPTH(6)) u_ft (.clk_i(clk), .rst_ni(rst_n), .bus(if2.slave));

    assign if0.valid_i = valid_i;  assign if1.valid_i = valid_i;  assign if2.valid_i = valid_i;
    assign if0.data_i  = data_i;   assign if1.data_i  = data_i;   assign if2.data_i  = data_i;
    assign if0.ready_i = ready_i;  assign if1.ready_i = ready_i;  assign if2.ready_i = ready_i;
    assign if0.flush_i = flush_i;  assign if1.flush_i = flush_i;  assign if2.flush_i = flush_i;
    assign if0.af_thresh_i = af_th[2:0]; assign if1.af_thresh_i = af_th; assign if2.af_thresh_i = af_th[2:0];
    assign if0.ae_thresh_i = ae_th[2:0]; assign if1.ae_thresh_i = ae_th; assign if2.ae_thresh_i = ae_th[2:0];

    logic        o_vld [3], o_rdy [3], o_af [3], o_ae [3];
    logic [31:0] o_dat [3];
    logic [3:0]  o_use [3], o_max [3];
    assign o_vld[0] = if0.valid_o; assign o_vld[1] = if1.valid_o; assign o_vld[2] = if2.valid_o;
    assign o_rdy[0] = if0.ready_o; assign o_rdy[1] = if1.ready_o; assign o_rdy[2] = if2.ready_o;
    assign o_af[0]  = if0.almost_full_o;  assign o_af[1] = if1.almost_full_o;  assign o_af[2] = if2.almost_full_o;
    assign o_ae[0]  = if0.almost_empty_o; assign o_ae[1] = if1.almost_empty_o; assign o_ae[2] = if2.almost_empty_o;
    assign o_dat[0] = if0.data_o; assign o_dat[1] = if1.data_o; assign o_dat[2] = if2.data_o;
    assign o_use[0] = {1'b0, if0.usage_o};     assign o_use[1] = if1.usage_o;     assign o_use[2] = {1'b0, if2.usage_o};
    assign o_max[0] = {1'b0, if0.max_usage_o}; assign o_max[1] = if1.max_usage_o; assign o_max[2] = {1'b0, if2.max_usage_o};

    // Reference model: ordered contents and watermark per instance.
    logic [31:0] mq [3][$];
    int          mmax [3];
    bit          exp_vld [3], exp_rdy [3];
    bit          hold_data = 1'b0;
    int          n_cmp = 0, n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int          sz;
            bit          ev, er;
            logic [31:0] ed;
            sz = mq[k].size();
            er = (sz != DEP[k]);
            if (sz == 0) begin
                ev = FTM[k] && valid_i;
                ed = ev ? data_i : 32'h0;
            end else begin
                ev = 1'b1;
                ed = mq[k][0];
            end
            exp_vld[k] = ev;
            exp_rdy[k] = er;
            chk($sformatf("k%0d ready_o", k), 32'(o_rdy[k]), 32'(er));
            chk($sformatf("k%0d valid_o", k), 32'(o_vld[k]), 32'(ev));
            chk($sformatf("k%0d data_o", k), o_dat[k], ed);
            chk($sformatf("k%0d usage_o", k), 32'(o_use[k]), 32'(sz));
            chk($sformatf("k%0d max_usage_o", k), 32'(o_max[k]), 32'(mmax[k]));
            chk($sformatf("k%0d almost_full_o", k), 32'(o_af[k]), 32'(sz >= int'(af_th)));
            chk($sformatf("k%0d almost_empty_o", k), 32'(o_ae[k]), 32'(sz <= int'(ae_th)));
        end
    endtask

    task automatic update_model();
        for (int k = 0; k < 3; k++) begin
            int sz;
            bit push, pop;
            sz = mq[k].size();
            if (flush_i) begin
                mq[k].delete();
                mmax[k] = 0;
            end else begin
                push = valid_i && exp_rdy[k];
                pop  = exp_vld[k] && ready_i;
                if (!(FTM[k] && sz == 0 && push && pop)) begin
                    if (pop)  void'(mq[k].pop_front());
                    if (push) mq[k].push_back(data_i);
                end
                if (mq[k].size() > mmax[k]) mmax[k] = mq[k].size();
            end
        end
    endtask

    // Entered and left at posedge+1 with inputs already driven.
    task automatic cycle();
        #1;
        check_all();
        hold_data = valid_i && !flush_i && !(exp_rdy[0] && exp_rdy[1] && exp_rdy[2]);
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        valid_i = v;
        if (!hold_data) data_i = d;
        ready_i = r;
        flush_i = f;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            mmax[k] = 0;
        end
        hold_data = 1'b0;
    endtask

    initial begin
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state, af_thresh 0 makes almost_full assert on empty.
        chk("rst ready_o", 32'(o_rdy[0]), 32'd1);
        chk("rst valid_o", 32'(o_vld[0]), 32'd0);
        chk("rst usage_o", 32'(o_use[1]), 32'd0);
        chk("rst max_usage_o", 32'(o_max[1]), 32'd0);
        chk("rst almost_empty_o", 32'(o_ae[0]), 32'd1);
        chk("rst almost_full_o af=0", 32'(o_af[0]), 32'd1);
        af_th = 4'd4;
        ae_th = 4'd1;

        // Fill A1..A5 with no consumer.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hA1 + 32'(i), 1'b0, 1'b0);
            cycle();
            if (i == 2) chk("af at usage 3", 32'(o_af[1]), 32'd0);
            if (i == 3) chk("af at usage 4", 32'(o_af[1]), 32'd1);
        end
        chk("D5 usage full", 32'(o_use[0]), 32'd5);
        chk("D5 ready full", 32'(o_rdy[0]), 32'd0);

        // Full with push and pop requested: only the pop happens on D5.
        drive(1'b1, 32'hB0, 1'b1, 1'b0);
        #1;
        chk("D5 full head", o_dat[0], 32'hA1);
        cycle();
        chk("D5 usage after full pop", 32'(o_use[0]), 32'd4);
        chk("D5 ready after full pop", 32'(o_rdy[0]), 32'd1);

        // Drain and check order.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            #1;
            if (i < 4) chk("D5 drain order", o_dat[0], 32'hA2 + 32'(i));
            chk("D8 drain order", o_dat[1], (i < 4) ? 32'hA2 + 32'(i) : 32'hB0);
            cycle();
        end
        chk("D5 valid after drain", 32'(o_vld[0]), 32'd0);
        chk("D8 valid after drain", 32'(o_vld[1]), 32'd0);
        chk("D8 max after drain", 32'(o_max[1]), 32'd5);
        chk("D8 ae after drain", 32'(o_ae[1]), 32'd1);

        // Pointer wrap on non-power-of-2 depth.
        for (int r = 3; r <= 4; r++) begin
            for (int i = 0; i < r; i++) begin
                drive(1'b1, 32'hC0 + 32'(16 * r + i), 1'b0, 1'b0);
                cycle();
            end
            for (int i = 0; i < r; i++) begin
                drive(1'b0, 32'h0, 1'b1, 1'b0);
                #1;
                chk("D5 wrap order", o_dat[0], 32'hC0 + 32'(16 * r + i));
                cycle();
            end
        end

        // Fill to 6 then flush with a push pending.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'hD1 + 32'(i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'hEE, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("flush usage D5", 32'(o_use[0]), 32'd0);
        chk("flush usage D8", 32'(o_use[1]), 32'd0);
        chk("flush max D8", 32'(o_max[1]), 32'd0);
        chk("flush valid D8", 32'(o_vld[1]), 32'd0);
        chk("flush ready D5", 32'(o_rdy[0]), 32'd1);
        chk("flush valid FT", 32'(o_vld[2]), 32'd0);
        cycle();

        // Fall-through bypass on empty.
        drive(1'b1, 32'h55, 1'b1, 1'b0);
        #1;
        chk("FT bypass valid", 32'(o_vld[2]), 32'd1);
        chk("FT bypass data", o_dat[2], 32'h55);
        chk("non-FT empty valid", 32'(o_vld[0]), 32'd0);
        cycle();
        chk("FT bypass usage", 32'(o_use[2]), 32'd0);
        chk("FT bypass max", 32'(o_max[2]), 32'd0);
        chk("non-FT took push", 32'(o_use[0]), 32'd1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            cycle();
        end

        // Randomised traffic, thresholds and occasional flush.
        for (int i = 0; i < 400; i++) begin
            bit v, r, f;
            if ($urandom_range(0, 15) == 0) begin
                af_th = 4'($urandom_range(0, 7));
                ae_th = 4'($urandom_range(0, 7));
            end
            v = (i < 200) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 4);
            r = (i < 200) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 29) == 0);
            drive(v, $urandom, r, f);
            cycle();
        end

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hF0 + 32'(i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst usage D5", 32'(o_use[0]), 32'd0);
        chk("arst usage D8", 32'(o_use[1]), 32'd0);
        chk("arst max D8", 32'(o_max[1]), 32'd0);
        chk("arst valid D5", 32'(o_vld[0]), 32'd0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h70 + 32'(i), 1'(i % 2), 1'b0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
